s_term_ram_io_port: RTL and testbench
=====================================

Name: s_term_ram_io_port

Overview:
- Parametrised next-generation south terminal tile for RAM columns.
- Passes the frame strobe and user clock through like existing terminal tiles.
- Adds a configuration register loaded from a configuration frame.
- Adds NUM_CH fabric-side RAM request channels, round-robin arbitrated onto one external RAM macro port with a req/ack handshake and a timeout.

Parameters:
MaxFramesPerCol, 20, width of FrameStrobe / FrameStrobe_O
FrameBitsPerRow, 32, width of FrameData / FrameData_O
NUM_CH, 2, fabric request channels (1..8; 2*NUM_CH <= FrameBitsPerRow)
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
CFG_FRAME, 0, FrameStrobe index that loads the configuration register
TIMEOUT, 15, max ISSUE cycles without ack; 0 disables the timeout

Ports:
UserCLK  in  1  tile clock
Reset  in  1  asynchronous, active-high reset
UserCLKo  out  1  UserCLK passed through (combinational)
FrameData  in  FrameBitsPerRow  configuration data
FrameData_O  out  FrameBitsPerRow  FrameData passed through (combinational)
FrameStrobe  in  MaxFramesPerCol  frame strobes
FrameStrobe_O  out  MaxFramesPerCol  FrameStrobe passed through (combinational)
fab_req  in  NUM_CH  per-channel request level
fab_we  in  NUM_CH  per-channel write request
fab_addr  in  NUM_CH*ADDR_W  channel c at [c*ADDR_W +: ADDR_W]
fab_wdata  in  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
fab_rdata  out  NUM_CH*DATA_W  per-channel read data, held between completions
fab_valid  out  NUM_CH  one-cycle completion pulse
fab_err  out  NUM_CH  one-cycle timeout pulse
ram_en  out  1  access request to RAM macro
ram_we  out  1  write strobe, qualified by ram_en
ram_addr  out  ADDR_W  access address
ram_wdata  out  DATA_W  write data
ram_rdata  in  DATA_W  read data, valid in the ack cycle
ram_ack  in  1  access complete

Behaviour:
- Reset (async): cfg, rr pointer, timeout counter, latched request = 0; FSM = IDLE; all ram_* outputs, fab_rdata, fab_valid, fab_err = 0. Pass-through outputs are unaffected by Reset.
- cfg register:
  - Loaded at a UserCLK edge with FrameStrobe[CFG_FRAME]=1: cfg <= FrameData[2*NUM_CH-1:0].
  - cfg[c] = channel c enable.
  - cfg[NUM_CH+c] = channel c write permit.
- Eligibility: fab_req[c] & cfg[c].
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any channel is eligible, grant the first eligible channel at or after rr pointer, wrapping modulo NUM_CH.
  - Latch grant index, fab_addr, fab_wdata, and we = fab_we[c] & cfg[NUM_CH+c].
  - Set rr <= (c+1) mod NUM_CH and go to ISSUE.
  - With no eligible channel, stay in IDLE.
  - ram_ack in IDLE is ignored.
- ISSUE:
  - ram_en=1; ram_we/ram_addr/ram_wdata come from the latched values and are stable for the whole state.
  - Counter increments each cycle.
  - On ram_ack: capture ram_rdata into fab_rdata[c] (reads only; writes leave it unchanged), set done-ok, go to DONE.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: set done-err, go to DONE.
  - ram_ack and timeout in the same cycle: ack wins.
- DONE:
  - ram_en=0; fab_valid[c]=1 (ok) or fab_err[c]=1 (err) for exactly this cycle.
  - Counter cleared; go to IDLE.
- Latency: request seen in IDLE at cycle n; ram_en=1 at n+1; with ack at n+1, fab_valid at n+2. Minimum is 3 cycles per access.
- Requester protocol: fab_req is a level; one access per grant. The requester must drop fab_req by the edge ending its fab_valid/fab_err cycle; otherwise the request is served again.
- cfg changes mid-transaction do not abort the granted access; eligibility is re-evaluated in IDLE only.
- A write to a channel without write permit performs a read: ram_we=0 and fab_rdata is updated.
- fab_valid and fab_err are never high together and at most one channel pulses per cycle.

Test Plan:
- Reset/cfg: assert Reset mid-ISSUE -> ram_en=0 immediately, FSM IDLE, outputs 0. Then FrameStrobe[0]=1 with FrameData=32'h0000_000F -> both channels enabled and write-permitted.
- Single read: ch0 fab_addr=8'h3C, ack one cycle after ram_en with ram_rdata=8'hA5 -> ram_addr=8'h3C, ram_we=0, fab_valid[0] at req+2 cycles, fab_rdata[7:0]=8'hA5 held afterwards.
- Round robin: ch0 and ch1 both requesting continuously (dropping req after valid) starting with rr=0 -> grants in order ch0, ch1, ch0; ram_addr follows each channel's address.
- Write permit: cfg=4'b0111 (ch1 no write permit), ch1 fab_we=1 with wdata=8'h5A -> ram_we=0 and fab_rdata[15:8] updated. Ch0 write with wdata=8'h5A -> ram_we=1, ram_wdata=8'h5A.
- Timeout: TIMEOUT=15, never ack -> ram_en high exactly 15 cycles, then fab_err pulse for one cycle, fab_rdata unchanged. Repeat with ram_ack in the 15th cycle -> fab_valid, not fab_err.
- Disabled channel and pass-through: cfg[1]=0 with fab_req[1]=1 -> no ram_en. FrameStrobe=20'h80001 -> FrameStrobe_O=20'h80001 in the same cycle, and UserCLKo follows UserCLK.

Source files
------------

// File: rtl/s_term_ram_io_port.sv
// s_term_ram_io_port: south RAM-column terminal tile with config frame register and arbitrated RAM port
// Ports: UserCLK/FrameData/FrameStrobe pass through combinationally; Reset is async active-high;
// fab_* are NUM_CH fabric request channels (req/we/addr/wdata in, rdata/valid/err out);
// ram_* is the single RAM macro port (en/we/addr/wdata out, rdata/ack in).
module s_term_ram_io_port #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CFG_FRAME = 0,
  parameter int TIMEOUT = 15
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  output logic                       UserCLKo,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  input  logic [NUM_CH-1:0]          fab_req,
  input  logic [NUM_CH-1:0]          fab_we,
  input  logic [NUM_CH*ADDR_W-1:0]   fab_addr,
  input  logic [NUM_CH*DATA_W-1:0]   fab_wdata,
  output logic [NUM_CH*DATA_W-1:0]   fab_rdata,
  output logic [NUM_CH-1:0]          fab_valid,
  output logic [NUM_CH-1:0]          fab_err,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_wdata,
  input  logic [DATA_W-1:0]          ram_rdata,
  input  logic                       ram_ack
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, nxt;
  logic [2*NUM_CH-1:0] cfg;
  logic [NUM_CH-1:0] elig, wp, sel;
  logic [IW-1:0] rr, gnt, pick;
  logic [CW-1:0] cnt;
  logic found, ok, we_l, timeout;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [ADDR_W-1:0] addr_a [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  logic [DATA_W-1:0] rd [NUM_CH];
  assign UserCLKo = UserCLK;
  assign FrameData_O = FrameData;
  assign FrameStrobe_O = FrameStrobe;
  assign elig = fab_req & cfg[NUM_CH-1:0];
  assign wp = cfg[2*NUM_CH-1:NUM_CH];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign addr_a[c] = fab_addr[c*ADDR_W +: ADDR_W];
    assign wdata_a[c] = fab_wdata[c*DATA_W +: DATA_W];
    assign fab_rdata[c*DATA_W +: DATA_W] = rd[c];
  end
  always_ff @(posedge UserCLK or posedge Reset)
    if (Reset) cfg <= '0;
    else if (FrameStrobe[CFG_FRAME]) cfg <= FrameData[2*NUM_CH-1:0];
  // first eligible channel at or after the round-robin pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (!found && elig[(int'(rr) + i) % NUM_CH]) begin
        found = 1'b1;
        pick = IW'((int'(rr) + i) % NUM_CH);
      end
    timeout = TIMEOUT != 0 && cnt == TLAST;
    nxt = state == IDLE  ? (found ? ISSUE : IDLE) :
          state == ISSUE ? (ram_ack || timeout ? DONE : ISSUE) : IDLE;
  end
  always_comb begin
    sel = '0;
    sel[gnt] = 1'b1;
  end
  assign fab_valid = state == DONE && ok ? sel : '0;
  assign fab_err = state == DONE && !ok ? sel : '0;
  assign ram_en = state == ISSUE;
  assign ram_we = ram_en & we_l;
  assign ram_addr = addr_l;
  assign ram_wdata = wdata_l;
  always_ff @(posedge UserCLK or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge UserCLK or posedge Reset)
    if (Reset) begin
      rr <= '0;
      gnt <= '0;
      cnt <= '0;
      ok <= 1'b0;
      we_l <= 1'b0;
      addr_l <= '0;
      wdata_l <= '0;
      for (int c = 0; c < NUM_CH; c++) rd[c] <= '0;
    end else begin
      if (state == IDLE && found) begin
        gnt <= pick;
        addr_l <= addr_a[pick];
        wdata_l <= wdata_a[pick];
        we_l <= fab_we[pick] & wp[pick];
        rr <= pick == IW'(NUM_CH - 1) ? '0 : pick + 1'b1;
      end
      // ok keeps the value of the final ISSUE cycle, which decides valid vs err in DONE
      if (state == ISSUE) begin
        cnt <= cnt + 1'b1;
        ok <= ram_ack;
        if (ram_ack && !we_l) rd[gnt] <= ram_rdata;
      end
      if (state == DONE) cnt <= '0;
    end
endmodule

// File: tb/tb_s_term_ram_io_port.sv
// tb_s_term_ram_io_port: randomized and directed checks of s_term_ram_io_port against a transaction-level model
module tb_s_term_ram_io_port;
  localparam int TO = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic clko;
  logic [31:0] frame_data = '0, frame_data_o;
  logic [19:0] frame_strobe = '0, frame_strobe_o;
  logic [1:0] fab_req = '0, fab_we = '0, fab_valid, fab_err;
  logic [15:0] fab_addr = '0, fab_wdata = '0, fab_rdata;
  logic ram_en, ram_we, ram_ack = 1'b0;
  logic [7:0] ram_addr, ram_wdata, ram_rdata = '0;
  int n_checks = 0, n_fail = 0;
  int rr_m = 0;
  logic [3:0] cfg_m = '0;
  logic [7:0] rd_m [2] = '{8'h00, 8'h00};
  always #5 clk = ~clk;
  s_term_ram_io_port #(.TIMEOUT(TO)) dut (
    .UserCLK(clk), .Reset(rst), .UserCLKo(clko),
    .FrameData(frame_data), .FrameData_O(frame_data_o),
    .FrameStrobe(frame_strobe), .FrameStrobe_O(frame_strobe_o),
    .fab_req(fab_req), .fab_we(fab_we), .fab_addr(fab_addr), .fab_wdata(fab_wdata),
    .fab_rdata(fab_rdata), .fab_valid(fab_valid), .fab_err(fab_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_cfg(input logic [31:0] d);
    fab_req = '0;
    frame_data = d;
    frame_strobe = 20'h1;
    tick();
    frame_strobe = '0;
    cfg_m = d[3:0];
  endtask
  // one request round: model picks the grant, decides ok/timeout and the resulting read data
  task automatic xact(input logic [1:0] req, input logic [1:0] we, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] w0, input logic [7:0] w1, input int ack_k, input logic [7:0] rd);
    logic [1:0] elig;
    int g, k_end;
    logic we_e, ok;
    fab_req = req;
    fab_we = we;
    fab_addr = {a1, a0};
    fab_wdata = {w1, w0};
    ram_ack = 1'b0;
    elig = req & cfg_m[1:0];
    if (elig == 2'b00) begin
      repeat (3) begin
        tick();
        check("idle_en", ram_en, 0);
      end
      fab_req = '0;
      return;
    end
    g = -1;
    for (int i = 0; i < 2; i++) if (g < 0 && elig[(rr_m + i) % 2]) g = (rr_m + i) % 2;
    we_e = we[g] & cfg_m[2 + g];
    ok = ack_k <= TO;
    k_end = ok ? ack_k : TO;
    tick();
    for (int k = 1; k <= k_end; k++) begin
      check("issue_en", ram_en, 1);
      check("addr", ram_addr, g == 1 ? a1 : a0);
      check("we", ram_we, we_e);
      if (we_e) check("wdata", ram_wdata, g == 1 ? w1 : w0);
      check("no_pulse", {fab_valid, fab_err}, 0);
      ram_ack = k == ack_k;
      ram_rdata = ram_ack ? rd : 8'($urandom);
      tick();
    end
    check("done_en", ram_en, 0);
    check("valid", fab_valid, ok ? (1 << g) : 0);
    check("err", fab_err, ok ? 0 : (1 << g));
    ram_ack = 1'b0;
    fab_req[g] = 1'b0;
    rr_m = (g + 1) % 2;
    if (ok && !we_e) rd_m[g] = rd;
    tick();
    check("pulse_end", {fab_valid, fab_err}, 0);
    check("idle_after", ram_en, 0);
    check("rdata", fab_rdata, {rd_m[1], rd_m[0]});
    fab_req = '0;
  endtask
  initial begin
    repeat (2) tick();
    check("rst_en", ram_en, 0);
    check("rst_rdata", fab_rdata, 0);
    check("rst_addr", ram_addr, 0);
    rst = 1'b0;
    load_cfg(32'h3);
    fab_req = 2'b01;
    fab_addr = 16'h0055;
    tick();
    check("pre_rst_en", ram_en, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_en", ram_en, 0);
    check("async_rst_addr", ram_addr, 0);
    check("async_rst_pulse", {fab_valid, fab_err}, 0);
    tick();
    rst = 1'b0;
    cfg_m = '0;
    rr_m = 0;
    tick();
    check("cfg_cleared", ram_en, 0);
    load_cfg(32'h0000_000F);
    xact(2'b01, 2'b00, 8'h3C, 8'h00, 8'h00, 8'h00, 1, 8'hA5);
    check("rdata0_A5", fab_rdata[7:0], 8'hA5);
    xact(2'b10, 2'b00, 8'h00, 8'h71, 8'h00, 8'h00, 1, 8'h11);
    repeat (3) xact(2'b11, 2'b00, 8'h20, 8'h21, 8'h00, 8'h00, 2, 8'($urandom));
    load_cfg(32'h0000_0007);
    xact(2'b10, 2'b10, 8'h10, 8'h44, 8'h00, 8'h5A, 1, 8'hC3);
    check("nowp_rdata1", fab_rdata[15:8], 8'hC3);
    xact(2'b01, 2'b01, 8'h45, 8'h00, 8'h5A, 8'h00, 1, 8'h99);
    xact(2'b01, 2'b00, 8'h46, 8'h00, 8'h00, 8'h00, 99, 8'h77);
    xact(2'b01, 2'b00, 8'h47, 8'h00, 8'h00, 8'h00, TO, 8'h66);
    load_cfg(32'h0000_000D);
    xact(2'b10, 2'b00, 8'h00, 8'h48, 8'h00, 8'h00, 1, 8'h00);
    frame_strobe = 20'h80001;
    frame_data = 32'h0000_000F;
    #1;
    check("strobe_pass", frame_strobe_o, 20'h80001);
    check("data_pass", frame_data_o, 32'h0000_000F);
    check("clko_hi", clko, clk);
    #4;
    check("clko_lo", clko, clk);
    tick();
    frame_strobe = '0;
    cfg_m = 4'hF;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 7) == 0) load_cfg($urandom);
      xact(2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           $urandom_range(1, TO + 3), 8'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
